row_col_sequencer: RTL and testbench
====================================

ROW_COL_SEQUENCER -- requirements
Module: row_col_sequencer

Interface
REQ-001 The block SHALL have parameter FEATURE_ROWS, default 6, meaning number of rows swept per pass (>=1).
REQ-002 The block SHALL have parameter WEIGHT_COLS, default 3, meaning number of columns swept per row (>=1).
REQ-003 The block SHALL have parameter COO_NUM_OF_COLS, default 6, meaning COO column count used to size coo_address.
REQ-004 The block SHALL have derived widths ROW_BW = max(1,$clog2(FEATURE_ROWS)), COL_BW = max(1,$clog2(WEIGHT_COLS)), and COO_BW = max(1,$clog2(COO_NUM_OF_COLS)).
REQ-005 The block SHALL have the following ports (clock and reset first): clk  in  1  single clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a pass.
REQ-008 abort  in  1  terminate the pass and return to idle.
REQ-009 enable_count  in  1  advance permission; low means stall.
REQ-010 busy  out  1  high in RUN.
REQ-011 addr_valid  out  1  high when row_count/col_count are a live address (RUN).
REQ-012 row_count  out  ROW_BW  current row.
REQ-013 col_count  out  COL_BW  current column.
REQ-014 coo_address  out  COO_BW  current COO column, equal to row_count zero-extended or truncated to COO_BW.
REQ-015 last_col / last_row  out  1 each  col_count==WEIGHT_COLS-1 / row_count==FEATURE_ROWS-1, qualified by addr_valid.
REQ-016 done  out  1  single-cycle pulse after the final address is consumed.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, and DONE.
REQ-018 In IDLE with start=1 and abort=0, the FSM SHALL go to RUN next cycle with row=0 and col=0, so the first address is valid the cycle after start.
REQ-019 In RUN with enable_count=1, the block SHALL advance col first; at col=WEIGHT_COLS-1, col SHALL wrap to 0 and row SHALL increment (row-major, column inner).
REQ-020 In RUN with enable_count=0, all counters and outputs SHALL hold.
REQ-021 In RUN with enable_count=1 at row=FEATURE_ROWS-1 and col=WEIGHT_COLS-1, the block SHALL go to DONE with counters cleared to 0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 A pass with no stalls SHALL take exactly FEATURE_ROWS*WEIGHT_COLS RUN cycles.
REQ-024 start in RUN or DONE SHALL be ignored; it is not queued.
REQ-025 abort=1 in any state SHALL force IDLE and zero counters next cycle, with no done pulse; abort SHALL win over simultaneous start and enable_count.
REQ-026 FEATURE_ROWS=1 or WEIGHT_COLS=1 SHALL be legal: the corresponding counter stays 0 and its last_* flag is high throughout RUN.
REQ-027 Counters SHALL never exceed their maximum value; wrap SHALL be by compare, not by power-of-two overflow.

Reset
REQ-028 reset_n low SHALL immediately force IDLE and set busy, addr_valid, row_count, col_count, coo_address, last_col, last_row, and done to 0.
REQ-029 Reset asserted mid-pass SHALL discard the pass, with no done pulse after release.
REQ-030 After reset_n deasserts, the first start SHALL be accepted on the next clk edge.

Configuration
REQ-031 With macro ROW_SEQ_STALL_CNT_EN defined, the block SHALL add output stall_count (16 bits) that counts RUN cycles with enable_count=0, clears on start acceptance, saturates at 16'hFFFF, and holds its value in IDLE/DONE.
REQ-032 Without ROW_SEQ_STALL_CNT_EN, the stall_count port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-033 Shared package gcn_seq_pkg SHALL hold the FSM state enum (seq_state_t) and the width helper function used for ROW_BW, COL_BW, and COO_BW.
REQ-034 The design SHALL use one sub-module, wrap_counter (parameter MAX, inputs clr/inc, outputs count/at_max), instantiated once for rows and once for columns.

Verification
REQ-035 Defaults, start, enable_count held at 1 -> addresses (0,0),(0,1),(0,2),(1,0)...(5,2) over 18 cycles, then done high for 1 cycle, then busy=0.
REQ-036 Defaults, enable_count low on every other RUN cycle -> same 18-address sequence over 36 cycles, each address held 2 cycles; with macro defined, stall_count=18 at done.
REQ-037 Abort at address (2,1) together with enable_count=1 -> next cycle IDLE with counters 0 and no done pulse; a following start restarts at (0,0).
REQ-038 reset_n pulsed low at address (4,0) -> outputs go to 0 asynchronously; no done pulse after release.
REQ-039 FEATURE_ROWS=1, WEIGHT_COLS=1 -> one RUN cycle with last_row=last_col=1, then done; a start during RUN or DONE is ignored.
REQ-040 FEATURE_ROWS=5, COO_NUM_OF_COLS=4 -> coo_address equals row_count truncated to 2 bits, and row wraps after 4 to end the pass.

Source files
------------

// File: rtl/gcn_seq_pkg.sv
// Shared types and helpers for the row/column address sequencer.
package gcn_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  // Counter width for n distinct values; a single-value counter still needs one bit.
  function automatic int seq_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/row_col_sequencer_wrap_counter.sv
// Up-counter that wraps from MAX back to 0 by compare, so non-power-of-two ranges never overshoot.
module wrap_counter #(
  parameter int MAX = 0,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q, count_d;

  assign at_max = (count_q == MAX_V);
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_max ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/row_col_sequencer.sv
// Row-major (column inner) address sweep over FEATURE_ROWS x WEIGHT_COLS with a done pulse.
// Optional stall counter output enabled by defining ROW_SEQ_STALL_CNT_EN.
module row_col_sequencer
  import gcn_seq_pkg::*;
#(
  parameter int  FEATURE_ROWS    = 6,
  parameter int  WEIGHT_COLS     = 3,
  parameter int  COO_NUM_OF_COLS = 6,
  localparam int ROW_BW          = seq_width(FEATURE_ROWS),
  localparam int COL_BW          = seq_width(WEIGHT_COLS),
  localparam int COO_BW          = seq_width(COO_NUM_OF_COLS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              enable_count,
  output logic              busy,
  output logic              addr_valid,
  output logic [ROW_BW-1:0] row_count,
  output logic [COL_BW-1:0] col_count,
  output logic [COO_BW-1:0] coo_address,
  output logic              last_col,
  output logic              last_row,
  output logic              done,
`ifdef ROW_SEQ_STALL_CNT_EN
  output logic [15:0]       stall_count,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: start is a one-cycle request honoured only in IDLE (never queued);
  // addr_valid marks a live address, which is consumed on each cycle enable_count is high.
  seq_state_t state_q, state_d;
  logic       row_at_max, col_at_max;
  logic       run_adv, pass_end, cnt_clr;

  assign run_adv  = (state_q == SEQ_RUN) && enable_count && !abort;
  assign pass_end = run_adv && row_at_max && col_at_max;
  assign cnt_clr  = abort || (state_q != SEQ_RUN) || pass_end;

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = SEQ_IDLE;
    end else begin
      case (state_q)
        SEQ_IDLE: if (start) state_d = SEQ_RUN;
        SEQ_RUN:  if (pass_end) state_d = SEQ_DONE;
        SEQ_DONE: state_d = SEQ_IDLE;
        default:  state_d = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  wrap_counter #(.MAX(WEIGHT_COLS - 1), .W(COL_BW)) u_col_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (run_adv),
    .count   (col_count),
    .at_max  (col_at_max)
  );

  wrap_counter #(.MAX(FEATURE_ROWS - 1), .W(ROW_BW)) u_row_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (run_adv && col_at_max),
    .count   (row_count),
    .at_max  (row_at_max)
  );

  assign busy        = (state_q == SEQ_RUN);
  assign addr_valid  = busy;
  assign done        = (state_q == SEQ_DONE);
  assign last_col    = addr_valid && col_at_max;
  assign last_row    = addr_valid && row_at_max;
  assign coo_address = COO_BW'(row_count);
  assign state_dbg   = state_q;

`ifdef ROW_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Cleared only when a pass is actually accepted so the value survives DONE/IDLE for readout.
  always_comb begin
    stall_d = stall_q;
    if (state_q == SEQ_IDLE && start && !abort) begin
      stall_d = '0;
    end else if (state_q == SEQ_RUN && !enable_count && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_row_col_sequencer.sv
// Directed bench for row_col_sequencer: default 6x3, a 1x1 instance and a 5-row/4-COO instance.
module tb_row_col_sequencer;

  logic clk = 1'b0;
  logic reset_n, start, abort, en;

  always #5 clk = ~clk;

  // default instance
  logic b0, v0, lc0, lr0, dn0;
  logic [2:0] r0, coo0;
  logic [1:0] c0, st0;
  logic [15:0] sc0;
  // 1x1 instance
  logic b1, v1, lc1, lr1, dn1;
  logic [0:0] r1, c1;
  logic [2:0] coo1;
  logic [1:0] st1;
  logic [15:0] sc1;
  // 5 rows, COO 4
  logic b2, v2, lc2, lr2, dn2;
  logic [2:0] r2;
  logic [1:0] c2, coo2, st2;
  logic [15:0] sc2;

  row_col_sequencer u_d0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .enable_count(en),
    .busy(b0), .addr_valid(v0), .row_count(r0), .col_count(c0), .coo_address(coo0),
    .last_col(lc0), .last_row(lr0), .done(dn0),
`ifdef ROW_SEQ_STALL_CNT_EN
    .stall_count(sc0),
`endif
    .state_dbg(st0)
  );

  row_col_sequencer #(.FEATURE_ROWS(1), .WEIGHT_COLS(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .enable_count(en),
    .busy(b1), .addr_valid(v1), .row_count(r1), .col_count(c1), .coo_address(coo1),
    .last_col(lc1), .last_row(lr1), .done(dn1),
`ifdef ROW_SEQ_STALL_CNT_EN
    .stall_count(sc1),
`endif
    .state_dbg(st1)
  );

  row_col_sequencer #(.FEATURE_ROWS(5), .COO_NUM_OF_COLS(4)) u_d2 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .enable_count(en),
    .busy(b2), .addr_valid(v2), .row_count(r2), .col_count(c2), .coo_address(coo2),
    .last_col(lc2), .last_row(lr2), .done(dn2),
`ifdef ROW_SEQ_STALL_CNT_EN
    .stall_count(sc2),
`endif
    .state_dbg(st2)
  );

`ifndef ROW_SEQ_STALL_CNT_EN
  assign sc0 = '0;
  assign sc1 = '0;
  assign sc2 = '0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic e);
    start = s;
    abort = a;
    en    = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cleanup();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  typedef struct {
    logic       start, abort, en;
    logic       busy, valid;
    logic [2:0] row;
    logic [1:0] col;
    logic       last_row, last_col, done;
    logic [1:0] state;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // table for an unstalled default pass; a stray start mid-pass must be ignored
    for (int i = 0; i < 20; i++) begin
      tbl[i].start = (i == 0) || (i == 5);
      tbl[i].abort = 1'b0;
      tbl[i].en    = 1'b1;
      if (i < 18) begin
        tbl[i].busy = 1'b1;  tbl[i].valid = 1'b1;
        tbl[i].row  = 3'(i / 3);
        tbl[i].col  = 2'(i % 3);
        tbl[i].last_row = (i / 3 == 5);
        tbl[i].last_col = (i % 3 == 2);
        tbl[i].done = 1'b0;  tbl[i].state = 2'd1;
      end else begin
        tbl[i].busy = 1'b0;  tbl[i].valid = 1'b0;
        tbl[i].row  = 3'd0;  tbl[i].col = 2'd0;
        tbl[i].last_row = 1'b0; tbl[i].last_col = 1'b0;
        tbl[i].done = (i == 18);
        tbl[i].state = (i == 18) ? 2'd2 : 2'd0;
      end
    end

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_busy", 32'(b0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_row", 32'(r0), 32'd0);
    chk("rst_col", 32'(c0), 32'd0);
    chk("rst_done", 32'(dn0), 32'd0);
    chk("rst_state", 32'(st0), 32'd0);
    #10;
    reset_n = 1'b1;
    tick();

    // unstalled pass
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].start, tbl[i].abort, tbl[i].en);
      tick();
      chk($sformatf("tbl%0d_busy", i), 32'(b0), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_valid", i), 32'(v0), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_row", i), 32'(r0), 32'(tbl[i].row));
      chk($sformatf("tbl%0d_col", i), 32'(c0), 32'(tbl[i].col));
      chk($sformatf("tbl%0d_coo", i), 32'(coo0), 32'(tbl[i].row));
      chk($sformatf("tbl%0d_lrow", i), 32'(lr0), 32'(tbl[i].last_row));
      chk($sformatf("tbl%0d_lcol", i), 32'(lc0), 32'(tbl[i].last_col));
      chk($sformatf("tbl%0d_done", i), 32'(dn0), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_state", i), 32'(st0), 32'(tbl[i].state));
    end
    cleanup();

    // stall on every other RUN cycle: 36 RUN cycles, each address held twice
    drive(1'b1, 1'b0, 1'b0);
    tick();
    chk("stall_first_row", 32'(r0), 32'd0);
    chk("stall_first_busy", 32'(b0), 32'd1);
    for (int j = 0; j < 36; j++) begin
      drive(1'b0, 1'b0, 1'(j % 2));
      tick();
      if (j < 35) begin
        chk($sformatf("stall%0d_row", j), 32'(r0), 32'(((j + 1) / 2) / 3));
        chk($sformatf("stall%0d_col", j), 32'(c0), 32'(((j + 1) / 2) % 3));
        chk($sformatf("stall%0d_busy", j), 32'(b0), 32'd1);
      end else begin
        chk("stall_done", 32'(dn0), 32'd1);
`ifdef ROW_SEQ_STALL_CNT_EN
        chk("stall_count", 32'(sc0), 32'd18);
`endif
      end
    end
    cleanup();

    // abort at (2,1) with start and enable also high
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) tick();
    chk("abort_pre_row", 32'(r0), 32'd2);
    chk("abort_pre_col", 32'(c0), 32'd1);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    chk("abort_busy", 32'(b0), 32'd0);
    chk("abort_row", 32'(r0), 32'd0);
    chk("abort_col", 32'(c0), 32'd0);
    chk("abort_done", 32'(dn0), 32'd0);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("abort_nodone", 32'(dn0), 32'd0);
    chk("abort_idle", 32'(b0), 32'd0);
    drive(1'b1, 1'b0, 1'b1);
    tick();
    chk("restart_busy", 32'(b0), 32'd1);
    chk("restart_row", 32'(r0), 32'd0);
    chk("restart_col", 32'(c0), 32'd0);
    cleanup();

    // asynchronous reset at (4,0)
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) tick();
    chk("rstmid_pre_row", 32'(r0), 32'd4);
    chk("rstmid_pre_col", 32'(c0), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(b0), 32'd0);
    chk("rstmid_valid", 32'(v0), 32'd0);
    chk("rstmid_row", 32'(r0), 32'd0);
    chk("rstmid_coo", 32'(coo0), 32'd0);
    chk("rstmid_lrow_lcol", 32'({lr0, lc0}), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    begin
      logic saw_done = 1'b0;
      logic saw_busy = 1'b0;
      for (int k = 0; k < 25; k++) begin
        tick();
        saw_done |= dn0;
        saw_busy |= b0;
      end
      chk("rstmid_no_done", 32'(saw_done), 32'd0);
      chk("rstmid_no_busy", 32'(saw_busy), 32'd0);
    end
    drive(1'b1, 1'b0, 1'b1);
    tick();
    chk("post_rst_start", 32'(b0), 32'd1);
    cleanup();

    // 1x1 pass: single RUN cycle, starts in RUN/DONE ignored
    drive(1'b1, 1'b0, 1'b1);
    tick();
    chk("one_busy", 32'(b1), 32'd1);
    chk("one_lrow", 32'(lr1), 32'd1);
    chk("one_lcol", 32'(lc1), 32'd1);
    chk("one_done_early", 32'(dn1), 32'd0);
    tick();
    chk("one_done", 32'(dn1), 32'd1);
    chk("one_busy_in_done", 32'(b1), 32'd0);
    tick();
    chk("one_idle", 32'(st1), 32'd0);
    chk("one_done_once", 32'(dn1), 32'd0);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("one_not_queued", 32'(b1), 32'd0);
    cleanup();

    // 5 rows, COO width 2: truncation and end of pass after row 4
    drive(1'b1, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("coo%0d_row", k), 32'(r2), 32'(k / 3));
      chk($sformatf("coo%0d_col", k), 32'(c2), 32'(k % 3));
      chk($sformatf("coo%0d_addr", k), 32'(coo2), 32'((k / 3) % 4));
      chk($sformatf("coo%0d_lrow", k), 32'(lr2), 32'(k / 3 == 4));
      drive(1'b0, 1'b0, 1'b1);
      tick();
    end
    chk("coo_done", 32'(dn2), 32'd1);
    chk("coo_row_clr", 32'(r2), 32'd0);
    cleanup();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
